// File: rtl/bit_serial_deser.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_deser
// Purpose  : Serial-to-parallel collector at the output end of the bit-serial
//            datapath. Assembles WIDTH-bit words from one bit per strobe and
//            presents each completed word on a valid/ready parallel port.
//
// Ports    : i_clk          system clock, rising edge
//            i_rst          synchronous reset, active-low
//            i_frame_start  discard partial word, restart bit count
//            i_bit_valid    strobe: i_bit sampled this cycle
//            i_bit          serial data bit
//            o_word         assembled word
//            o_word_valid   o_word holds an unconsumed word
//            i_word_ready   consumer accepts o_word this cycle
//            o_busy         partial word in progress
//            o_bit_count    bits received in current word
//            o_overrun      sticky: a completed word was dropped
//
// Options  : DESER_SKID_EN  when defined, a one-entry skid register sits
//                           behind o_word and absorbs one extra completed
//                           word while the consumer stalls.
//
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_deser #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_frame_start,
    input  logic                     i_bit_valid,
    input  logic                     i_bit,
    output logic [WIDTH-1:0]         o_word,
    output logic                     o_word_valid,
    input  logic                     i_word_ready,
    output logic                     o_busy,
    output logic [$clog2(WIDTH)-1:0] o_bit_count,
    output logic                     o_overrun
);

    localparam int               c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    // Collector state: IDLE whenever the bit count is zero.
    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_word;
    logic               r_word_valid;
    logic               r_overrun;
`ifdef DESER_SKID_EN
    logic [WIDTH-1:0]   r_skid;
    logic               r_skid_valid;
`endif

    logic [c_CNT_W-1:0] w_cnt_base;
    logic [WIDTH-1:0]   w_shift_base;
    logic [WIDTH-1:0]   w_shift_ins;
    logic               w_last;
    logic               w_done;
    logic               w_consume;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;

    // A frame start clears the partial word before any same-cycle bit is
    // inserted, so that bit becomes the first bit of the new word.
    always_comb begin
        w_cnt_base   = i_frame_start ? '0 : r_count;
        w_shift_base = i_frame_start ? '0 : r_shift;

        // LSB-first shifts right so the first bit ends up in bit 0 after
        // WIDTH insertions; MSB-first shifts left.
        if (LSB_FIRST) begin
            w_shift_ins            = w_shift_base >> 1;
            w_shift_ins[WIDTH-1]   = i_bit;
        end else begin
            w_shift_ins            = w_shift_base << 1;
            w_shift_ins[0]         = i_bit;
        end

        w_last    = (w_cnt_base == c_LAST);
        w_done    = i_bit_valid && w_last;
        w_consume = r_word_valid && i_word_ready;

        w_count_nxt = w_cnt_base;
        w_shift_nxt = w_shift_base;
        if (i_bit_valid) begin
            if (w_last) begin
                w_count_nxt = '0;
                w_shift_nxt = '0;
            end else begin
                w_count_nxt = w_cnt_base + c_ONE;
                w_shift_nxt = w_shift_ins;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= c_S_IDLE;
            r_shift      <= '0;
            r_count      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef DESER_SKID_EN
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
`endif
        end else begin
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;

            case (r_state)
                c_S_IDLE: begin
                    if (w_count_nxt != '0)
                        r_state <= c_S_SHIFT;
                end
                c_S_SHIFT: begin
                    if (w_count_nxt == '0)
                        r_state <= c_S_IDLE;
                end
                default: r_state <= c_S_IDLE;
            endcase

`ifdef DESER_SKID_EN
            // o_word is the head of a two-entry queue; the skid is the tail.
            if (w_consume) begin
                if (r_skid_valid) begin
                    r_word <= r_skid;
                    if (w_done)
                        r_skid <= w_shift_ins;
                    else
                        r_skid_valid <= 1'b0;
                end else if (w_done) begin
                    r_word <= w_shift_ins;
                end else begin
                    r_word_valid <= 1'b0;
                end
            end else if (!r_word_valid) begin
                if (w_done) begin
                    r_word       <= w_shift_ins;
                    r_word_valid <= 1'b1;
                end
            end else if (w_done) begin
                if (!r_skid_valid) begin
                    r_skid       <= w_shift_ins;
                    r_skid_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
`else
            // A completing word may replace the held one only when the held
            // one is being consumed on this same edge; otherwise it is lost.
            if (w_done && (!r_word_valid || w_consume)) begin
                r_word       <= w_shift_ins;
                r_word_valid <= 1'b1;
            end else begin
                if (w_consume)
                    r_word_valid <= 1'b0;
                if (w_done)
                    r_overrun <= 1'b1;
            end
`endif
        end
    end

    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;
    assign o_busy       = (r_state == c_S_SHIFT);
    assign o_bit_count  = r_count;
    assign o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_deser
// Purpose  : Self-checking bench for bit_serial_deser. Directed scenarios
//            followed by random traffic, compared every cycle against a
//            queue-based reference model of bit collection and output
//            buffering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serial_deser;

    localparam int WIDTH     = 8;
    localparam bit LSB_FIRST = 1'b1;
    localparam int CW        = $clog2(WIDTH);
`ifdef DESER_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             r_clk = 1'b0;
    logic             r_rst = 1'b0;
    logic             r_frame_start = 1'b0;
    logic             r_bit_valid = 1'b0;
    logic             r_bit = 1'b0;
    logic             r_word_ready = 1'b0;
    logic [WIDTH-1:0] w_word;
    logic             w_word_valid;
    logic             w_busy;
    logic [CW-1:0]    w_bit_count;
    logic             w_overrun;

    bit_serial_deser #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_dut (
        .i_clk         (r_clk),
        .i_rst         (r_rst),
        .i_frame_start (r_frame_start),
        .i_bit_valid   (r_bit_valid),
        .i_bit         (r_bit),
        .o_word        (w_word),
        .o_word_valid  (w_word_valid),
        .i_word_ready  (r_word_ready),
        .o_busy        (w_busy),
        .o_bit_count   (w_bit_count),
        .o_overrun     (w_overrun)
    );

    always #5 r_clk = ~r_clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: received bits of the current word, and the queue of
    // completed words waiting at the output (capacity 1, or 2 with skid).
    bit               m_bits[$];
    logic [WIDTH-1:0] m_out[$];
    logic [WIDTH-1:0] m_last_word = '0;
    logic             m_overrun = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst_n, fs, bv, b, rdy);
        logic [WIDTH-1:0] nw;
        bit               have_new;
        have_new = 0;
        nw       = '0;
        if (!rst_n) begin
            m_bits.delete();
            m_out.delete();
            m_overrun   = 1'b0;
            m_last_word = '0;
            return;
        end
        if (fs) m_bits.delete();
        if (bv) m_bits.push_back(b);
        if (m_bits.size() == WIDTH) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (LSB_FIRST) nw[i] = m_bits[i];
                else           nw[WIDTH-1-i] = m_bits[i];
            end
            m_bits.delete();
            have_new = 1;
        end
        if (m_out.size() > 0 && rdy) void'(m_out.pop_front());
        if (have_new) begin
            if (m_out.size() < CAP) m_out.push_back(nw);
            else                    m_overrun = 1'b1;
        end
        if (m_out.size() > 0) m_last_word = m_out[0];
    endtask

    task automatic check_all();
        chk("word_valid", 32'(w_word_valid), 32'(m_out.size() > 0));
        chk("word",       32'(w_word),       32'(m_last_word));
        chk("busy",       32'(w_busy),       32'(m_bits.size() != 0));
        chk("bit_count",  32'(w_bit_count),  32'(m_bits.size()));
        chk("overrun",    32'(w_overrun),    32'(m_overrun));
    endtask

    task automatic cycle(input logic rst_n, fs, bv, b, rdy);
        r_rst         = rst_n;
        r_frame_start = fs;
        r_bit_valid   = bv;
        r_bit         = b;
        r_word_ready  = rdy;
        @(posedge r_clk);
        model_step(rst_n, fs, bv, b, rdy);
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy);
        for (int i = 0; i < WIDTH; i++)
            cycle(1'b1, 1'b0, 1'b1, LSB_FIRST ? w[i] : w[WIDTH-1-i], rdy);
    endtask

    initial begin
        // Reset held for three clocks while strobes are active.
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b1);
        chk("rst_valid", 32'(w_word_valid), 32'd0);
        chk("rst_count", 32'(w_bit_count), 32'd0);
        chk("rst_word",  32'(w_word), 32'd0);

        // Single word, output valid for exactly one cycle.
        send_word(8'hA5, 1'b1);
        chk("a5_valid", 32'(w_word_valid), 32'd1);
        chk("a5_word",  32'(w_word), 32'hA5);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("a5_drop", 32'(w_word_valid), 32'd0);

        // Frame restart discards a partial word.
        send_word(8'h3C, 1'b1);
        chk("3c_word", 32'(w_word), 32'h3C);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 1'b1, 1'($urandom), 1'b1);
        chk("part_count", 32'(w_bit_count), 32'd4);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("fs_count", 32'(w_bit_count), 32'd0);
        send_word(8'hFF, 1'b1);
        chk("ff_word", 32'(w_word), 32'hFF);

        // Frame start with a same-cycle strobe keeps that bit.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("fs_bv_count", 32'(w_bit_count), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Consumer stalled across two words.
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        chk("stall_word", 32'(w_word), 32'h11);
        chk("stall_ovr",  32'(w_overrun), 32'(CAP == 1));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h33, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_cleared", 32'(w_overrun), 32'd0);

        // Back-to-back words without a gap.
        send_word(8'h0F, 1'b1);
        chk("b2b_w0", 32'(w_word), 32'h0F);
        send_word(8'hF0, 1'b1);
        chk("b2b_w1", 32'(w_word), 32'hF0);
        chk("b2b_v1", 32'(w_word_valid), 32'd1);

        // Reset in the middle of a word.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("mid_rst_count", 32'(w_bit_count), 32'd0);
        chk("mid_rst_busy",  32'(w_busy), 32'd0);
        send_word(8'h96, 1'b1);
        chk("clean_word", 32'(w_word), 32'h96);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 7),
                  1'($urandom),
                  1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
